// File: rtl/mem_controller.sv
// Round-robin arbiter that funnels per-consumer read/write requests onto one memory port,
// one transaction at a time, and relays the completion back to the granted consumer.
module mem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter bit          WRITE_ENABLE  = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid_i,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address_i,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready_o,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_o,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid_i,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address_i,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data_i,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready_o,
    output logic                               mem_read_valid_o,
    output logic [ADDR_BITS-1:0]               mem_read_address_o,
    input  logic                               mem_read_ready_i,
    input  logic [DATA_BITS-1:0]               mem_read_data_i,
    output logic                               mem_write_valid_o,
    output logic [ADDR_BITS-1:0]               mem_write_address_o,
    output logic [DATA_BITS-1:0]               mem_write_data_o,
    input  logic                               mem_write_ready_i
);

    localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int unsigned SumW = IdxW + 1;

    typedef enum logic [1:0] {StIdle, StReadWait, StWriteWait, StRelay} state_e;

    state_e                         state_q, state_d;
    logic [IdxW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]                grant_q, grant_d;
    logic                           is_write_q, is_write_d;
    logic                           mem_rv_q, mem_rv_d;
    logic                           mem_wv_q, mem_wv_d;
    logic [ADDR_BITS-1:0]           mem_ra_q, mem_ra_d;
    logic [ADDR_BITS-1:0]           mem_wa_q, mem_wa_d;
    logic [DATA_BITS-1:0]           mem_wd_q, mem_wd_d;
    logic [NUM_CONSUMERS-1:0]       crr_q, crr_d;
    logic [NUM_CONSUMERS-1:0]       cwr_q, cwr_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

    logic [NUM_CONSUMERS-1:0] rd_req, wr_req;
    logic                     found;
    logic                     pick_write;
    logic [IdxW-1:0]          pick, scan;
    logic                     granted_valid;

    // With the write path removed, write requests are simply invisible to the arbiter.
    assign rd_req = consumer_read_valid_i;
    assign wr_req = WRITE_ENABLE ? consumer_write_valid_i : '0;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] a,
                                                 input logic [IdxW-1:0] b);
        logic [SumW-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= SumW'(NUM_CONSUMERS)) sum = sum - SumW'(NUM_CONSUMERS);
        return sum[IdxW-1:0];
    endfunction

    always_comb begin
        found      = 1'b0;
        pick_write = 1'b0;
        pick       = '0;
        scan       = '0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            scan = wrap_add(rr_ptr_q, IdxW'(i));
            if (!found && (rd_req[scan] || wr_req[scan])) begin
                found      = 1'b1;
                pick       = scan;
                pick_write = !rd_req[scan];
            end
        end
    end

    assign granted_valid = is_write_q ? wr_req[grant_q] : rd_req[grant_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        is_write_d = is_write_q;
        mem_rv_d   = mem_rv_q;
        mem_wv_d   = mem_wv_q;
        mem_ra_d   = mem_ra_q;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;
        crr_d      = crr_q;
        cwr_d      = cwr_q;
        crd_d      = crd_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d    = pick;
                    rr_ptr_d   = wrap_add(pick, IdxW'(1));
                    is_write_d = pick_write;
                    if (pick_write) begin
                        mem_wv_d = 1'b1;
                        mem_wa_d = consumer_write_address_i[pick*ADDR_BITS +: ADDR_BITS];
                        mem_wd_d = consumer_write_data_i[pick*DATA_BITS +: DATA_BITS];
                        state_d  = StWriteWait;
                    end else begin
                        mem_rv_d = 1'b1;
                        mem_ra_d = consumer_read_address_i[pick*ADDR_BITS +: ADDR_BITS];
                        state_d  = StReadWait;
                    end
                end
            end
            StReadWait: begin
                if (mem_read_ready_i) begin
                    mem_rv_d                                  = 1'b0;
                    crd_d[grant_q*DATA_BITS +: DATA_BITS]     = mem_read_data_i;
                    crr_d[grant_q]                            = 1'b1;
                    state_d                                   = StRelay;
                end
            end
            StWriteWait: begin
                if (mem_write_ready_i) begin
                    mem_wv_d       = 1'b0;
                    cwr_d[grant_q] = 1'b1;
                    state_d        = StRelay;
                end
            end
            StRelay: begin
                // Hold completion until the consumer withdraws its request.
                if (!granted_valid) begin
                    crr_d[grant_q] = 1'b0;
                    cwr_d[grant_q] = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            is_write_q <= 1'b0;
            mem_rv_q   <= 1'b0;
            mem_wv_q   <= 1'b0;
            mem_ra_q   <= '0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            crr_q      <= '0;
            cwr_q      <= '0;
            crd_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            is_write_q <= is_write_d;
            mem_rv_q   <= mem_rv_d;
            mem_wv_q   <= mem_wv_d;
            mem_ra_q   <= mem_ra_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            crr_q      <= crr_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
        end
    end

    assign consumer_read_ready_o  = crr_q;
    assign consumer_read_data_o   = crd_q;
    assign consumer_write_ready_o = cwr_q;
    assign mem_read_valid_o       = mem_rv_q;
    assign mem_read_address_o     = mem_ra_q;
    assign mem_write_valid_o      = mem_wv_q;
    assign mem_write_address_o    = mem_wa_q;
    assign mem_write_data_o       = mem_wd_q;

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Sits directly downstream of the per-thread load/store units.
- Arbitrates NUM_CONSUMERS independent valid/ready read and write request channels onto one external memory port.
- Relays read data or write completion back to the granted consumer.
- Handles one memory transaction at a time, with round-robin fairness across consumers.

Parameters:
ADDR_BITS, 8, address width per request
DATA_BITS, 8, data width per request
NUM_CONSUMERS, 4, number of LSU request channels (>=1)
WRITE_ENABLE, 1, 0 = write path removed: consumer_write_ready and mem_write_valid held 0, write requests never granted

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  output  NUM_CONSUMERS  per-consumer read completion
consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, valid while matching ready=1
consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request
consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion
mem_read_valid  output  1  external read request
mem_read_address  output  ADDR_BITS  external read address
mem_read_ready  input  1  external read done, mem_read_data valid
mem_read_data  input  DATA_BITS  external read data
mem_write_valid  output  1  external write request
mem_write_address  output  ADDR_BITS  external write address
mem_write_data  output  DATA_BITS  external write data
mem_write_ready  input  1  external write accepted

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; rr_ptr=0; granted index 0. Takes effect immediately, including mid-transaction: mem valids drop without waiting for ready, any in-flight transaction is abandoned.
- State machine with states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers rr_ptr, rr_ptr+1, ... (mod NUM_CONSUMERS); first with read_valid or write_valid wins.
  - Read beats write for the same consumer.
  - On grant: latch index g; rr_ptr <= (g+1) mod NUM_CONSUMERS.
  - Read grant: drive mem_read_valid=1 and mem_read_address; go to READ_WAIT.
  - Write grant: drive mem_write_valid=1, mem_write_address and mem_write_data; go to WRITE_WAIT.
  - Mem outputs are registered: consumer valid sampled at edge k gives mem valid high after edge k.
- READ_WAIT: mem_read_valid and address held stable until mem_read_ready is sampled 1. On that edge:
  - mem_read_valid <= 0;
  - consumer_read_data slice g <= mem_read_data;
  - consumer_read_ready[g] <= 1;
  - go to RELAY.
- WRITE_WAIT: same pattern, using mem_write_ready. On that edge: mem_write_valid <= 0; consumer_write_ready[g] <= 1; go to RELAY.
- RELAY:
  - Hold ready[g] (and read data slice) until the granted consumer's matching valid is sampled 0.
  - On that edge: clear ready[g] and go to IDLE. The data slice keeps its value.
  - Consumer ready is therefore high for at least 1 cycle, typically 2 with an LSU that drops valid on the edge it samples ready.
- Only one consumer ready bit is ever high at a time. Ungranted consumers see ready=0.
- Once granted, a request is not abortable: if the consumer drops valid early, the memory transaction still completes, ready pulses for 1 cycle, then IDLE.
- A new grant can occur no earlier than the edge after RELAY exits.
- rr_ptr changes only on grant. Wrap from NUM_CONSUMERS-1 to 0.
- mem_read_valid and mem_write_valid are never both 1.
- Minimum turnaround with zero memory wait (ready high the cycle valid rises): request edge -> mem valid (+1) -> consumer ready (+2) -> IDLE (+4, with a standard LSU).

Test Plan:
- Read: consumer 0 reads addr 0x12; memory returns 0x5A with 1-cycle ready -> mem_read_address=0x12; consumer_read_ready[0]=1 with data slice 0 = 0x5A; other ready bits 0; mem_read_valid low after ready.
- Write: consumer 2 writes 0x77 to addr 0x30; mem_write_ready delayed 5 cycles -> mem_write_valid/address/data held stable all 5 cycles; consumer_write_ready[2] rises the cycle after ready is sampled.
- Contention: consumers 0, 1, 3 request together from reset -> grant order 0, 1, 3. Consumer 0 re-requests immediately -> order 0, 1, 3, 0, never 0 twice in a row.
- Same consumer read+write simultaneously: consumer 1 asserts both -> read served first, then write. mem_read_valid and mem_write_valid never overlap.
- Reset mid-READ_WAIT: assert reset while mem_read_valid=1 -> all outputs 0 without a clock edge. After release, a fresh request from consumer 3 is granted first (rr_ptr=0, consumer 3 the only requester).
- Early valid drop: consumer 0 drops read_valid during READ_WAIT -> transaction still completes, ready[0] high exactly 1 cycle, return to IDLE.
